// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_REQ   = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int DEF_PC_INC   = 4;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_TIMEOUT  = 15;

  // Timeout counter width: wide enough for TIMEOUT, never narrower than 4 bits.
  function automatic int ctr_width(input int tmo);
    int w;
    w = $clog2(tmo + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// MFA/MFC memory handshake between the fetch sequencer and the RAM.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MFA;
  logic              MFC;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output MFA, MAR, input MFC, mem_rdata);
  modport slave  (input MFA, MAR, output MFC, mem_rdata);
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Load-clear counter; tc flags that the MFA wait has reached TIMEOUT cycles.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic Clk,
  input  logic Clr,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [CW-1:0] cnt;

  // Clear wins over increment so a completing access restarts from zero.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(TIMEOUT));
endmodule

// File: rtl/fetch_sequencer.sv
// Self-sequencing fetch unit: PC->MAR, MFA until MFC, data->MDR->IR, then PC/nPC advance.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                PC_INC   = DEF_PC_INC,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 run,
  input  logic                 step,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    br_target,
  fetch_sequencer_if.master    mem,
  output logic [DATA_W-1:0]    MDR,
  output logic [DATA_W-1:0]    IR,
  output logic [ADDR_W-1:0]    PC,
  output logic [ADDR_W-1:0]    nPC,
  output logic                 ir_valid,
  output logic                 fault,
  output logic                 busy
);
  localparam int                CW  = ctr_width(TIMEOUT);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  state_t            state, state_n;
  logic [ADDR_W-1:0] mar_q;
  logic              tc;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT), .CW(CW)) u_tmo (
    .Clk (Clk),
    .Clr (Clr),
    .clr (state != S_REQ || mem.MFC),
    .inc (state == S_REQ),
    .tc  (tc)
  );

  // Moore outputs; MFA derives from state so an async Clr drops it at once.
  assign mem.MFA = (state == S_REQ);
  assign mem.MAR = mar_q;
  assign busy    = (state != S_IDLE) && (state != S_FAULT);

  // State register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; step outside S_IDLE is simply not looked at.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (run || step) state_n = S_ADDR;
      S_ADDR:  state_n = S_REQ;
      S_REQ:   if (mem.MFC) state_n = S_LATCH;
               else if (tc) state_n = S_FAULT;
      S_LATCH: state_n = S_DONE;
      S_DONE:  if (!stall) state_n = run ? S_ADDR : S_IDLE;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath registers; branch redirect is delayed one slot (applies to nPC).
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mar_q    <= '0;
      MDR      <= '0;
      IR       <= '0;
      PC       <= RESET_PC;
      nPC      <= RESET_PC + INC;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      ir_valid <= (state == S_LATCH);
      case (state)
        S_ADDR:  mar_q <= PC;
        S_REQ:   if (mem.MFC) MDR <= mem.mem_rdata;
                 else if (tc) fault <= 1'b1;
        S_LATCH: IR <= MDR;
        S_DONE:  if (!stall) begin
                   PC  <= nPC;
                   nPC <= br_taken ? br_target : nPC + INC;
                 end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench with a scoreboard: expected {PC, IR} pushed at stimulus, popped on ir_valid.
module tb_fetch_sequencer;
  logic        Clk, Clr, run, step, stall, br_taken;
  logic [31:0] br_target;
  logic [31:0] MDR, IR, PC, nPC;
  logic        ir_valid, fault, busy;

  logic        run8;
  logic [31:0] MDR8, IR8;
  logic [7:0]  PC8, nPC8;
  logic        ir_valid8, fault8, busy8;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  fetch_sequencer_if #(.ADDR_W(8),  .DATA_W(32)) bus8 ();

  fetch_sequencer dut (
    .Clk(Clk), .Clr(Clr), .run(run), .step(step), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .mem(bus),
    .MDR(MDR), .IR(IR), .PC(PC), .nPC(nPC),
    .ir_valid(ir_valid), .fault(fault), .busy(busy)
  );

  // Narrow-address instance started at F8 so its second nPC crosses the wrap.
  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'hF8)) dut8 (
    .Clk(Clk), .Clr(Clr), .run(run8), .step(1'b0), .stall(1'b0),
    .br_taken(1'b0), .br_target(8'h00), .mem(bus8),
    .MDR(MDR8), .IR(IR8), .PC(PC8), .nPC(nPC8),
    .ir_valid(ir_valid8), .fault(fault8), .busy(busy8)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // RAM model: MFC rises after wait_n MFA cycles, or never when tie0 is set.
  logic [31:0] mem [0:63];
  int          wait_n = 0;
  logic        tie0   = 1'b0;
  int          wcnt   = 0;

  always @(posedge Clk) wcnt <= bus.MFA ? wcnt + 1 : 0;
  assign bus.MFC       = !tie0 && bus.MFA && (wcnt >= wait_n);
  assign bus.mem_rdata = bus.MFC ? mem[bus.MAR[7:2]] : 32'hDEADBEEF;
  assign bus8.MFC       = bus8.MFA;
  assign bus8.mem_rdata = 32'h0100_0000;

  typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0, ir_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every IR update must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Clr && ir_valid) begin
      ir_cnt++;
      if (q.size() == 0) begin
        chk("sb_extra_ir", IR, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_ir", IR, e.ir);
        chk("sb_pc", PC, e.pc);
        chk("sb_mar", bus.MAR, e.pc);
      end
    end
  end

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.ir = mem[pc[7:2]];
    q.push_back(e);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge Clk);
    step = 1'b0;
  endtask

  task automatic wait_irv(input string nm, input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!ir_valid && cyc < lim);
    chk(nm, ir_valid, 1'b1);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  task automatic do_reset();
    Clr = 1'b0;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
  endtask

  initial begin
    int cyc, len, mbad, n;
    Clr = 1'b0; run = 1'b0; step = 1'b0; stall = 1'b0;
    br_taken = 1'b0; br_target = '0; run8 = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h9E04_4012;
    repeat (3) @(negedge Clk);

    // Reset state.
    chk("rst_pc", PC, 32'h0);
    chk("rst_npc", nPC, 32'h4);
    chk("rst_mar", bus.MAR, 32'h0);
    chk("rst_mdr", MDR, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_flags", {ir_valid, fault, busy, bus.MFA}, 4'b0000);

    // Clr in the middle of S_REQ drops MFA without waiting for an edge.
    wait_n = 100;
    Clr = 1'b1; run = 1'b1;
    n = 0;
    while (!bus.MFA && n < 10) begin @(negedge Clk); n++; end
    chk("midreq_mfa_up", bus.MFA, 1'b1);
    @(negedge Clk);
    Clr = 1'b0;
    #1;
    chk("midreq_mfa", bus.MFA, 1'b0);
    chk("midreq_pc", PC, 32'h0);
    chk("midreq_npc", nPC, 32'h4);
    chk("midreq_ir", IR, 32'h0);
    chk("midreq_fault", fault, 1'b0);
    run = 1'b0;
    @(negedge Clk);

    // Run mode, zero-wait RAM: first IR lands 4 cycles after reset release.
    wait_n = 0;
    push(32'h0); push(32'h4);
    run = 1'b1; Clr = 1'b1;
    wait_irv("run_irv", 20, cyc);
    chk("run_latency", cyc, 4);
    @(negedge Clk);
    chk("run_pc", PC, 32'h4);
    chk("run_npc", nPC, 32'h8);
    @(negedge Clk);
    chk("run_mar2", bus.MAR, 32'h4);
    run = 1'b0;
    wait_idle("run_park", 20);
    chk("park_pc", PC, 32'h8);
    chk("park_npc", nPC, 32'hC);

    // Single step; a second step while busy is dropped.
    n = ir_cnt;
    push(32'h8);
    pulse_step();
    @(negedge Clk);
    pulse_step();
    wait_idle("step_idle", 20);
    repeat (8) @(negedge Clk);
    chk("step_count", ir_cnt - n, 1);
    chk("step_busy", busy, 1'b0);
    chk("step_pc", PC, 32'hC);

    // Delayed branch from PC=0, nPC=4 to 0x40.
    do_reset();
    push(32'h0);
    pulse_step();
    wait_irv("br_irv", 20, cyc);
    br_taken = 1'b1; br_target = 32'h40;
    @(negedge Clk);
    br_taken = 1'b0;
    chk("br_pc", PC, 32'h4);
    chk("br_npc", nPC, 32'h40);
    push(32'h4);
    pulse_step();
    wait_irv("slot_irv", 20, cyc);
    wait_idle("slot_idle", 10);
    push(32'h40);
    pulse_step();
    wait_irv("tgt_irv", 20, cyc);

    // Stall with br_taken high: stall wins, branch resampled on the leaving edge.
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("stall_pc", PC, 32'h40);
      chk("stall_npc", nPC, 32'h44);
    end
    stall = 1'b0; br_taken = 1'b0;
    @(negedge Clk);
    chk("unstall_pc", PC, 32'h44);
    chk("unstall_npc", nPC, 32'h48);
    wait_idle("unstall_idle", 10);

    // Five wait states: MFA high six cycles with MAR steady.
    wait_n = 5;
    push(32'h44);
    pulse_step();
    len = 0; mbad = 0; n = 0;
    while (n < 30 && !(len > 0 && !bus.MFA)) begin
      @(negedge Clk);
      n++;
      if (bus.MFA) begin
        len++;
        if (bus.MAR !== 32'h44) mbad++;
      end
    end
    chk("wait_mfa_len", len, 6);
    chk("wait_mar_moves", mbad, 0);
    wait_idle("wait_idle", 10);
    wait_n = 0;

    // Timeout: count reaches TIMEOUT after 15 MFA cycles, fault taken on the next edge.
    tie0 = 1'b1;
    do_reset();
    run = 1'b1;
    len = 0; n = 0;
    while (!fault && n < 60) begin
      @(negedge Clk);
      n++;
      if (bus.MFA) len++;
    end
    chk("tmo_fault", fault, 1'b1);
    chk("tmo_mfa_len", len, 16);
    chk("tmo_mfa", bus.MFA, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    mbad = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_step();
      @(negedge Clk);
      if (bus.MFA || busy) mbad++;
    end
    chk("tmo_sticky", fault, 1'b1);
    chk("tmo_no_restart", mbad, 0);
    run = 1'b0; tie0 = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
    #1;
    chk("tmo_clr", fault, 1'b0);

    // 8-bit address wrap: nPC FC -> 00.
    @(negedge Clk);
    Clr = 1'b1;
    chk("wrap_rst_npc", nPC8, 8'hFC);
    run8 = 1'b1;
    n = 0;
    while (!ir_valid8 && n < 20) begin @(negedge Clk); n++; end
    chk("wrap_irv", ir_valid8, 1'b1);
    run8 = 1'b0;
    @(negedge Clk);
    chk("wrap_pc", PC8, 8'hFC);
    chk("wrap_npc", nPC8, 8'h00);

    repeat (3) @(negedge Clk);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
